// File: rtl/quad_pkg.sv
// quad_pkg: phase/state types and the quadrature transition decoder.
package quad_pkg;
  typedef enum logic [1:0] {PH_00 = 2'b00, PH_01 = 2'b01, PH_10 = 2'b10, PH_11 = 2'b11} phase_t;
  typedef enum logic {ST_INIT, ST_TRACK} state_t;
  typedef enum logic [1:0] {TR_NONE, TR_FWD, TR_REV, TR_ILLEGAL} trans_t;
  // Forward successor of {a,b} is {~b,a}; reverse successor is {b,~a}.
  function automatic trans_t decode(input phase_t prev, input phase_t cur);
    logic [1:0] p;
    p = prev;
    return (cur == prev) ? TR_NONE :
           (cur == phase_t'({~p[0], p[1]})) ? TR_FWD :
           (cur == phase_t'({p[0], ~p[1]})) ? TR_REV : TR_ILLEGAL;
  endfunction
endpackage

// File: rtl/quad_filter.sv
// quad_filter: synchroniser chain followed by a stability filter for one encoder channel.
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic raw,
  output logic synced,
  output logic filt
);
  localparam int CW = $clog2(FILT_CYCLES + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic accept;
  assign synced = sync[SYNC_STAGES-1];
  assign accept = cnt == CW'(FILT_CYCLES);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      filt <= (load || accept) ? synced : filt;
      cnt  <= (load || accept || synced == filt) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: filtered quadrature decode into up/down strobes with illegal-transition counting.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  output logic             up,
  output logic             down,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int SW = $clog2(SYNC_STAGES + 2);
  state_t state, state_nx;
  phase_t prev, cur, syn;
  trans_t tr;
  logic [SW-1:0] settle;
  logic a_s, b_s, a_f, b_f, load, act, fwd, rev, ill;
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_fa (
    .clk(clk), .rst(rst), .load(load), .raw(a_in), .synced(a_s), .filt(a_f));
  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_fb (
    .clk(clk), .rst(rst), .load(load), .raw(b_in), .synced(b_s), .filt(b_f));
  assign load = state == ST_INIT;
  assign cur  = phase_t'({a_f, b_f});
  assign syn  = phase_t'({a_s, b_s});
  assign tr   = decode(prev, cur);
  assign act  = state == ST_TRACK && en;
  assign fwd  = act && tr == TR_FWD;
  assign rev  = act && tr == TR_REV;
  assign ill  = act && tr == TR_ILLEGAL;
  assign step = up | down;
  always_comb begin
    state_nx = (load && settle == SW'(SYNC_STAGES)) ? ST_TRACK : state;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else state <= state_nx;
  end
  // During INIT prev follows what the filters are loading, so it matches them on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle  <= '0;
      prev    <= PH_00;
      up      <= 1'b0;
      down    <= 1'b0;
      err     <= 1'b0;
      dir     <= 1'b1;
      err_cnt <= '0;
    end else begin
      settle  <= load ? settle + SW'(1) : '0;
      prev    <= load ? syn : cur;
      up      <= fwd;
      down    <= rev;
      err     <= ill;
      dir     <= fwd ? 1'b1 : rev ? 1'b0 : dir;
      err_cnt <= (ill && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: directed quadrature vectors with hand-computed strobe counts and latencies.
module tb_quad_decoder;
  logic clk = 1'b0, rst = 1'b1, a_in = 1'b0, b_in = 1'b0, en = 1'b1;
  logic up, down, step, dir, err;
  logic [7:0] err_cnt;
  int checks = 0, errors = 0;
  int ups, downs, errs, stps, lat;
  logic [1:0] fwd_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
  always #5 clk = ~clk;
  quad_decoder dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .en(en),
    .up(up), .down(down), .step(step), .dir(dir), .err(err), .err_cnt(err_cnt));
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input logic a, input logic b, input int n);
    a_in = a;
    b_in = b;
    ups = 0; downs = 0; errs = 0; stps = 0; lat = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (up) ups++;
      if (down) downs++;
      if (err) errs++;
      if (step) stps++;
      if ((up || down) && lat < 0) lat = i - 1;
    end
  endtask
  task automatic move(input string tag, input logic a, input logic b, input int n,
                      input int eu, input int ed, input int ee);
    run(a, b, n);
    check({tag, "_up"}, ups, eu);
    check({tag, "_down"}, downs, ed);
    check({tag, "_err"}, errs, ee);
    check({tag, "_step"}, stps, eu + ed);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_up"}, int'(up), 0);
    check({tag, "_down"}, int'(down), 0);
    check({tag, "_step"}, int'(step), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_dir"}, int'(dir), 1);
    check({tag, "_errcnt"}, int'(err_cnt), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    move("settle", 1'b0, 1'b0, 10, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      move($sformatf("fwd%0d", i), fwd_seq[i][1], fwd_seq[i][0], 10, 1, 0, 0);
      check($sformatf("fwd%0d_lat", i), lat, 6);
    end
    check("fwd_dir", int'(dir), 1);
    check("fwd_errcnt", int'(err_cnt), 0);
    for (int i = 0; i < 4; i++) begin
      move($sformatf("rev%0d", i), rev_seq[i][1], rev_seq[i][0], 10, 0, 1, 0);
      check($sformatf("rev%0d_lat", i), lat, 6);
    end
    check("rev_dir", int'(dir), 0);
    run(1'b1, 1'b0, 2);
    check("glitch_hi", ups + downs + errs, 0);
    move("glitch_lo", 1'b0, 1'b0, 10, 0, 0, 0);
    move("post_glitch", 1'b1, 1'b0, 10, 1, 0, 0);
    move("back00", 1'b0, 1'b0, 10, 0, 1, 0);
    move("ill", 1'b1, 1'b1, 10, 0, 0, 1);
    check("ill_errcnt", int'(err_cnt), 1);
    check("ill_dir", int'(dir), 0);
    for (int i = 0; i < 300; i++) run(i % 2 == 1, i % 2 == 1, 5);
    run(1'b1, 1'b1, 10);
    check("sat_errcnt", int'(err_cnt), 255);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    move("rst11", 1'b1, 1'b1, 10, 0, 0, 0);
    check("rst11_errcnt", int'(err_cnt), 0);
    check("rst11_dir", int'(dir), 1);
    move("rst11_fwd", 1'b0, 1'b1, 10, 1, 0, 0);
    move("pre_en_rev", 1'b1, 1'b1, 10, 0, 1, 0);
    en = 1'b0;
    move("dis1", 1'b0, 1'b1, 10, 0, 0, 0);
    move("dis2", 1'b0, 1'b0, 10, 0, 0, 0);
    check("dis_dir", int'(dir), 0);
    en = 1'b1;
    move("en_fwd", 1'b1, 1'b0, 10, 1, 0, 0);
    check("en_dir", int'(dir), 1);
    move("ill2", 1'b0, 1'b1, 10, 0, 0, 1);
    check("ill2_errcnt", int'(err_cnt), 1);
    move("rev2", 1'b1, 1'b1, 10, 0, 1, 0);
    run(1'b0, 1'b1, 4);
    check("midrst_pending", ups + downs + errs, 0);
    check("midrst_dir_before", int'(dir), 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    move("post_rst", 1'b0, 1'b1, 12, 0, 0, 0);
    check("post_rst_errcnt", int'(err_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature decoder that turns the two phase signals (A, B) of an incremental encoder into single-cycle up/down step strobes. It is the producing end of the up/down/enable interface consumed by the team's 8-bit up/down counter: `up`, `down` and `step` wire directly to the counter's `up`, `down` and `en` inputs. It synchronises and glitch-filters the asynchronous pins, tracks the Gray-code phase, and flags and counts illegal transitions.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per channel; minimum 2.
- `FILT_CYCLES`, 3: consecutive cycles a synchronised level must hold before it is accepted; minimum 1.
- `ERR_W`, 8: width of the error counter.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a_in`  in  1  encoder phase A; asynchronous to `clk`.
- `b_in`  in  1  encoder phase B; asynchronous to `clk`.
- `en`  in  1  strobe enable; phase tracking continues while low.
- `up`  out  1  one-cycle pulse per forward quarter-step.
- `down`  out  1  one-cycle pulse per reverse quarter-step.
- `step`  out  1  `up | down`.
- `dir`  out  1  last valid direction; 1 = forward.
- `err`  out  1  one-cycle pulse on an illegal transition.
- `err_cnt`  out  ERR_W  saturating count of illegal transitions.

## Operation
- Phase code is {A,B}. The forward sequence is 00→10→11→01→00 (A leads B). The reverse sequence is the opposite order.
- Per channel: SYNC_STAGES flop chain, then a filter.
  - The filter holds `filt`.
  - A stability counter increments while the synced value ≠ `filt` and clears when they are equal.
  - When the counter reaches FILT_CYCLES, `filt` takes the synced value and the counter clears.
- The FSM has states INIT and TRACK, plus a registered previous phase `prev`.
  - **INIT** (entered on reset): the filters load the synced value directly, bypassing stability counting. A settle counter runs SYNC_STAGES+1 cycles. On exit to TRACK, `prev` = current filtered code. No strobe or `err` is produced in INIT.
  - **TRACK**: each cycle, compare the filtered code with `prev`.
    - Equal: no event.
    - One-bit change in the forward direction: `up`, `dir`←1.
    - One-bit change in the reverse direction: `down`, `dir`←0.
    - Two-bit change: `err`, `err_cnt`+1 (saturates at 2^ERR_W−1), `dir` unchanged.
    - In all cases `prev` ← current code.
- `up` and `down` are never high together. `step` = `up | down`.
- `en` low suppresses `up`, `down`, `step` and `err` pulses and freezes `err_cnt` and `dir`. `prev` still tracks, so re-enabling produces no spurious step.
- Reset values: `up`=`down`=`step`=`err`=0, `dir`=1, `err_cnt`=0, FSM=INIT, all sync and filter flops 0.
- Reset asserted mid-operation clears all state on the next edge; any pending strobe is dropped.

## Timing
- All outputs are registered.
- Latency: a clean level change held stable produces its strobe exactly SYNC_STAGES + FILT_CYCLES + 1 cycles after the first edge that samples the new level (6 cycles with the defaults).
- Pulses shorter than FILT_CYCLES cycles after synchronisation are discarded.
- Maximum decodable rate is one quarter-step per FILT_CYCLES+1 cycles. Faster input may be reported as `err`.
- Two channel changes accepted in the same cycle count as illegal, even when each is individually legal.

## Structure
- Package `quad_pkg` holds:
  - the phase typedef `phase_t` (PH_00, PH_10, PH_11, PH_01);
  - the FSM state typedef (ST_INIT, ST_TRACK);
  - the transition-decode function returning FWD/REV/NONE/ILLEGAL.
- Sub-module `quad_filter` (synchroniser plus stability filter, parameterised by SYNC_STAGES and FILT_CYCLES) is instantiated once per channel.
- The top level contains the FSM, the output registers and the error counter.

## Test plan
- **Forward:** reset with A=B=0; drive 00→10→11→01→00, each held 10 cycles → four `up` pulses, each 1 cycle wide, each 6 cycles after its edge; `down`=0, `dir`=1, `err_cnt`=0.
- **Reverse:** drive 00→01→11→10→00 → four `down` pulses, `dir`=0, no `up`.
- **Glitch:** A high for 2 cycles, then low → no strobe, no `err`, filtered code stays 00.
- **Illegal and saturation:**
  - Step 00→11 → one `err` pulse, `err_cnt`=1, no `up`/`down`.
  - Then 300 alternating 00/11 steps with ERR_W=8 → `err_cnt` holds 255.
- **Reset at non-zero phase:** release reset with A=B=1 → no `err`, no strobe; then 11→01 → exactly one `up`.
- **Enable and mid-operation reset:**
  - `en`=0 across two forward steps → no strobes, `dir` unchanged; raise `en`, take one more forward step → exactly one `up`.
  - Assert `rst` during a filter count → no strobe; all outputs at reset values.
